// File: rtl/fusiont_seq_ctrl.sv
// fusiont_seq_ctrl: registered sequencer producing one "start ##1 a[*A] then b[*B]"
// pattern per accepted go. The b phase either follows a (overlap=0) or shares the
// final a cycle (overlap=1).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   go                    pattern request, sampled only while idle
//   a_len, bc_len         a/b phase lengths (CW bits), captured with go
//   overlap               1 = b starts on the last a cycle, 0 = b follows a
//   abort                 terminate the running pattern (no done pulse)
//   start, a, b, c        registered stimulus strobes (c = last b cycle)
//   busy, done            handshake: busy in every non-idle state, done one cycle
//   err_cfg               one-cycle pulse after a go with a zero length field
//   seq_cnt[15:0]         completed-pattern count (only with FUSIONT_SEQ_CNT_EN)
//
// Optional feature macro: FUSIONT_SEQ_CNT_EN
module fusiont_seq_ctrl #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [CW-1:0] a_len,
  input  logic [CW-1:0] bc_len,
  input  logic          overlap,
  input  logic          abort,
  output logic          start,
  output logic          a,
  output logic          b,
  output logic          c,
  output logic          busy,
  output logic          done,
  output logic          err_cfg
`ifdef FUSIONT_SEQ_CNT_EN
  ,
  output logic [15:0]   seq_cnt
`endif
);

  localparam int unsigned SCW = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_A_PH  = 3'd2,
    S_BC_PH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] a_len_q, bc_len_q;
  logic          overlap_q;
  logic          cfg_ld;
  logic          cfg_ok;

  logic start_q, a_q, b_q, c_q, busy_q, done_q, err_cfg_q;
  logic start_d, a_d, b_d, c_d, busy_d, done_d, err_cfg_d;

  // State, counter and latched configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_len_q   <= '0;
      bc_len_q  <= '0;
      overlap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cfg_ld) begin
        a_len_q   <= a_len;
        bc_len_q  <= bc_len;
        overlap_q <= overlap;
      end
    end
  end

  // Next state / counter
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cfg_ld    = 1'b0;
    err_cfg_d = 1'b0;
    cfg_ok    = (a_len != '0) && (bc_len != '0);
    unique case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        err_cfg_d = go && !cfg_ok;
        if (go && !abort && cfg_ok) begin
          state_d = S_START;
          cfg_ld  = 1'b1;
        end
      end
      S_START: begin
        state_d = S_A_PH;
        cnt_d   = a_len_q;
      end
      S_A_PH: begin
        if (cnt_q == CW'(1)) begin
          if (overlap_q && (bc_len_q == CW'(1))) begin
            // fused single b cycle already emitted alongside the last a
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_BC_PH;
            cnt_d   = overlap_q ? (bc_len_q - CW'(1)) : bc_len_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BC_PH: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Output decode from the upcoming state/counter so the flops show it in step
  always_comb begin
    start_d = (state_d == S_START);
    a_d     = (state_d == S_A_PH);
    b_d     = (state_d == S_BC_PH) ||
              ((state_d == S_A_PH) && (cnt_d == CW'(1)) && overlap_q);
    c_d     = ((state_d == S_BC_PH) && (cnt_d == CW'(1))) ||
              ((state_d == S_A_PH) && (cnt_d == CW'(1)) && overlap_q &&
               (bc_len_q == CW'(1)));
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      c_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_cfg_q <= 1'b0;
    end else begin
      start_q   <= start_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_cfg_q <= err_cfg_d;
    end
  end

  assign start   = start_q;
  assign a       = a_q;
  assign b       = b_q;
  assign c       = c_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cfg = err_cfg_q;

`ifdef FUSIONT_SEQ_CNT_EN
  logic [SCW-1:0] seq_cnt_q;

  // Completed-pattern counter, bumps as the done cycle begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt_q <= '0;
    end else if (state_d == S_DONE) begin
      seq_cnt_q <= seq_cnt_q + SCW'(1);
    end
  end

  assign seq_cnt = seq_cnt_q;
`endif

endmodule
